// File: rtl/data_mem_ctrl_pkg.sv
// Shared types for the core data-memory port.
//   mem_in_s          : request bundle from the core (write data, valid, wen, byte op, yumi)
//   mem_out_s         : response bundle to the core (read data, valid, yumi)
//   dmem_ctrl_state_e : controller FSM states
//   byte_lane_mask    : byte-enable pattern for a word or single-byte access
package data_mem_ctrl_pkg;

    typedef struct packed {
        logic [31:0] write_data;
        logic        valid;
        logic        wen;
        logic        byte_not_word;
        logic        yumi;
    } mem_in_s;

    typedef struct packed {
        logic [31:0] read_data;
        logic        valid;
        logic        yumi;
    } mem_out_s;

    typedef enum logic [1:0] {
        DCTRL_IDLE,
        DCTRL_WAIT,
        DCTRL_RESP
    } dmem_ctrl_state_e;

    // Byte ops enable only the addressed lane (little-endian); word ops enable all four.
    function automatic logic [3:0] byte_lane_mask(input logic       byte_not_word,
                                                  input logic [1:0] lane);
        if (byte_not_word) begin
            return 4'b0001 << lane;
        end
        return 4'b1111;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised RAM with per-byte write enables and a registered read port.
//   clk     : clock
//   addr_i  : word index
//   wdata_i : write data, lane i = bits [8i+7:8i]
//   be_i    : per-lane write enable
//   wen_i   : write strobe
//   ren_i   : read strobe; rdata_o updates on the following edge and holds otherwise
//   rdata_o : registered read data
// Contents are not reset.
module dmem_array #(
    parameter int unsigned addr_width_p = 10
) (
    input  logic                    clk,
    input  logic [addr_width_p-1:0] addr_i,
    input  logic [31:0]             wdata_i,
    input  logic [3:0]              be_i,
    input  logic                    wen_i,
    input  logic                    ren_i,
    output logic [31:0]             rdata_o
);

    localparam int unsigned Depth = 2 ** addr_width_p;

    logic [31:0] mem [Depth];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (wen_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
        if (ren_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory target for the core LD/ST port with a two-phase valid/yumi handshake.
//   clk        : clock
//   reset      : synchronous, active-high
//   to_mem_i   : request from core (write_data, valid, wen, byte_not_word, yumi)
//   addr_i     : byte address, sampled only when a request is accepted
//   from_mem_o : response to core (read_data, valid, yumi)
//   err_o      : sticky flag, set by any misaligned or out-of-range access since reset
// One request is outstanding at a time: IDLE accepts, WAIT burns latency_p cycles, RESP
// presents the result until the core yumis.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int unsigned dmem_addr_width_p = 10,
    parameter int unsigned latency_p         = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  mem_in_s     to_mem_i,
    input  logic [31:0] addr_i,
    output mem_out_s    from_mem_o,
    output logic        err_o
);

    localparam bit          Lat0    = (latency_p == 0);
    localparam int unsigned CntW    = (latency_p > 0) ? $clog2(latency_p + 1) : 1;
    localparam int unsigned CntInit = (latency_p > 0) ? latency_p - 1 : 0;
    localparam int unsigned WordMsb = dmem_addr_width_p + 1;

    dmem_ctrl_state_e state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [31:0]      req_addr_q, req_wdata_q;
    logic             req_wen_q, req_byte_q;
    logic             err_q;

    logic             accept, do_access;
    logic [31:0]      acc_addr, acc_wdata;
    logic             acc_wen, acc_byte, acc_err, resp_err;
    logic             ram_wen, ram_ren;
    logic [3:0]       ram_be;
    logic [31:0]      ram_wdata, ram_rdata;
    logic [7:0]       rd_byte;

    function automatic logic access_err(input logic [31:0] addr, input logic byte_not_word);
        logic misaligned, out_of_range;
        misaligned   = !byte_not_word && (addr[1:0] != 2'b00);
        out_of_range = (addr >> (dmem_addr_width_p + 2)) != 32'd0;
        return misaligned || out_of_range;
    endfunction

    assign accept = (state_q == DCTRL_IDLE) && to_mem_i.valid;

    // With zero latency the access happens in the accept cycle, straight from the inputs;
    // otherwise it happens in the last WAIT cycle from the latched request.
    assign acc_addr  = Lat0 ? addr_i                  : req_addr_q;
    assign acc_wdata = Lat0 ? to_mem_i.write_data     : req_wdata_q;
    assign acc_wen   = Lat0 ? to_mem_i.wen            : req_wen_q;
    assign acc_byte  = Lat0 ? to_mem_i.byte_not_word  : req_byte_q;
    assign do_access = Lat0 ? accept : ((state_q == DCTRL_WAIT) && (cnt_q == '0));
    assign acc_err   = access_err(acc_addr, acc_byte);

    // Reset in the same cycle must abort the access, so a store still in WAIT never lands.
    assign ram_wen   = do_access && acc_wen && !acc_err && !reset;
    assign ram_ren   = do_access && !acc_wen && !acc_err && !reset;
    assign ram_be    = byte_lane_mask(acc_byte, acc_addr[1:0]);
    assign ram_wdata = acc_byte ? {4{acc_wdata[7:0]}} : acc_wdata;

    dmem_array #(
        .addr_width_p(dmem_addr_width_p)
    ) u_array (
        .clk    (clk),
        .addr_i (acc_addr[WordMsb:2]),
        .wdata_i(ram_wdata),
        .be_i   (ram_be),
        .wen_i  (ram_wen),
        .ren_i  (ram_ren),
        .rdata_o(ram_rdata)
    );

    // Request regs are latched at accept in every build, so RESP can always use them.
    assign resp_err = access_err(req_addr_q, req_byte_q);
    assign rd_byte  = ram_rdata[{req_addr_q[1:0], 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= DCTRL_IDLE;
            cnt_q       <= '0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wen_q   <= 1'b0;
            req_byte_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                req_addr_q  <= addr_i;
                req_wdata_q <= to_mem_i.write_data;
                req_wen_q   <= to_mem_i.wen;
                req_byte_q  <= to_mem_i.byte_not_word;
            end
            if (do_access && acc_err) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        from_mem_o = '0;
        unique case (state_q)
            DCTRL_IDLE: begin
                from_mem_o.yumi = to_mem_i.valid;
                if (to_mem_i.valid) begin
                    state_d = Lat0 ? DCTRL_RESP : DCTRL_WAIT;
                    cnt_d   = CntW'(CntInit);
                end
            end
            DCTRL_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DCTRL_RESP;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            DCTRL_RESP: begin
                from_mem_o.valid = 1'b1;
                // Stores and faulting accesses report zero data.
                if (!req_wen_q && !resp_err) begin
                    from_mem_o.read_data = req_byte_q ? {24'd0, rd_byte} : ram_rdata;
                end
                if (to_mem_i.yumi) begin
                    state_d = DCTRL_IDLE;
                end
            end
            default: begin
                state_d = DCTRL_IDLE;
            end
        endcase
    end

    assign err_o = err_q;

endmodule
